// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin writeback arbiter feeding the issue stage
//
// Purpose:
//   Accepts completed scalar results from NUM_FU functional units over a
//   valid/ready handshake. Each unit has a one-entry holding register.
//   One full entry per cycle is chosen round-robin and loaded into a
//   registered writeback bundle. Issue uses that bundle to clear
//   scoreboard/FUST state and to write the register file.
//
// Optional feature:
//   WB_STALL_CNT_EN - adds output wb_stall_cnt, a saturating 32-bit count
//   of cycles in which at least one holding register is full but not
//   granted.
//
// Ports:
//   CLK, nRST     clock, asynchronous active-low reset
//   fu_valid      per-FU result valid
//   fu_ready      per-FU holding register can accept (combinational)
//   fu_rd         per-FU destination register, FU i at [i*REG_W +: REG_W]
//   fu_data       per-FU result data, FU i at [i*DATA_W +: DATA_W]
//   fu_wen        per-FU register-write enable
//   freeze        hold writeback outputs, no new grant
//   wb_valid      writeback bundle valid
//   wb_wen        register write enable (qualified by wb_valid)
//   wb_rd         destination register
//   wb_fu         index of the producing FU
//   wb_stall_cnt  stall cycle counter (WB_STALL_CNT_EN only)
//   s_wdata       writeback data

module wb_arbiter #(
    parameter int NUM_FU = 4,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int FU_W   = 2
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [NUM_FU-1:0]        fu_valid,
    output logic [NUM_FU-1:0]        fu_ready,
    input  logic [NUM_FU*REG_W-1:0]  fu_rd,
    input  logic [NUM_FU*DATA_W-1:0] fu_data,
    input  logic [NUM_FU-1:0]        fu_wen,
    input  logic                     freeze,
    output logic                     wb_valid,
    output logic                     wb_wen,
    output logic [REG_W-1:0]         wb_rd,
    output logic [FU_W-1:0]          wb_fu,
`ifdef WB_STALL_CNT_EN
    output logic [31:0]              wb_stall_cnt,
`endif
    output logic [DATA_W-1:0]        s_wdata
);

    // Holding registers, one entry per functional unit
    logic [NUM_FU-1:0] r_full;
    logic [NUM_FU-1:0] r_wen;
    logic [REG_W-1:0]  r_rd   [NUM_FU];
    logic [DATA_W-1:0] r_data [NUM_FU];

    // Round-robin pointer: index scanned first on the next grant
    logic [FU_W-1:0]   r_rr;

    // Registered writeback bundle
    logic              r_wb_valid;
    logic              r_wb_wen;
    logic [REG_W-1:0]  r_wb_rd;
    logic [FU_W-1:0]   r_wb_fu;
    logic [DATA_W-1:0] r_wb_data;

    logic [NUM_FU-1:0] w_grant;
    logic [FU_W-1:0]   w_gnt_idx;
    logic              w_any;
    logic [FU_W-1:0]   w_rr_next;
    logic [NUM_FU-1:0] w_accept;

    // (base + off) mod NUM_FU; NUM_FU need not be a power of two
    function automatic logic [FU_W-1:0] wrap_idx(input logic [FU_W-1:0] base, input int off);
        return FU_W'((int'(base) + off) % NUM_FU);
    endfunction

    // Grant: first full entry at or after r_rr, wrapping. Nothing is granted
    // while frozen, so the output bundle and the pointer both hold.
    always_comb begin
        w_grant   = '0;
        w_gnt_idx = '0;
        w_any     = 1'b0;
        for (int j = 0; j < NUM_FU; j++) begin
            if (!w_any && !freeze && r_full[wrap_idx(r_rr, j)]) begin
                w_any     = 1'b1;
                w_gnt_idx = wrap_idx(r_rr, j);
            end
        end
        if (w_any) begin
            w_grant[w_gnt_idx] = 1'b1;
        end
        w_rr_next = wrap_idx(w_gnt_idx, 1);
    end

    // An entry can take a new result when it is empty or draining this
    // cycle. w_grant is already zero under freeze. fu_valid is deliberately
    // not used here, so there is no combinational valid->ready path.
    assign fu_ready = ~r_full | w_grant;
    assign w_accept = fu_valid & fu_ready;

    // Holding registers. A same-cycle drain and refill leaves the entry
    // full with the new contents, so capture takes priority over clear.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_full <= '0;
            r_wen  <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_accept[i]) begin
                    r_full[i] <= 1'b1;
                    r_wen[i]  <= fu_wen[i];
                    r_rd[i]   <= fu_rd[i*REG_W +: REG_W];
                    r_data[i] <= fu_data[i*DATA_W +: DATA_W];
                end else if (w_grant[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
        end
    end

    // Writeback bundle and round-robin pointer. Data fields keep their last
    // value when idle; only valid and wen drop. Under freeze everything holds.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rr       <= '0;
            r_wb_valid <= 1'b0;
            r_wb_wen   <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_fu    <= '0;
            r_wb_data  <= '0;
        end else if (w_any) begin
            r_rr       <= w_rr_next;
            r_wb_valid <= 1'b1;
            r_wb_wen   <= r_wen[w_gnt_idx];
            r_wb_rd    <= r_rd[w_gnt_idx];
            r_wb_fu    <= w_gnt_idx;
            r_wb_data  <= r_data[w_gnt_idx];
        end else if (!freeze) begin
            r_wb_valid <= 1'b0;
            r_wb_wen   <= 1'b0;
        end
    end

    assign wb_valid = r_wb_valid;
    assign wb_wen   = r_wb_wen;
    assign wb_rd    = r_wb_rd;
    assign wb_fu    = r_wb_fu;
    assign s_wdata  = r_wb_data;

`ifdef WB_STALL_CNT_EN
    // A cycle counts as a stall when some full entry is left waiting,
    // whether from contention or from freeze.
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = |(r_full & ~w_grant);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign wb_stall_cnt = r_stall_cnt;
`endif

endmodule
